// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM state type and
// FIFO entry width helper.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_DROP = 2'd2
  } ifu_state_e;

  // A FIFO entry carries {pc, instruction}.
  function automatic int unsigned ifu_entry_w(input int unsigned word_size);
    return 2 * word_size;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory-request and decode-side signals of the fetch unit, grouped as one bus.
// master = fetch unit, slave = memory/decode environment.
interface inst_fetch_unit_if #(
  parameter int unsigned WORD_SIZE = 16
) ();

  logic                 mem_read;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_ready;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 inst_valid;
  logic [WORD_SIZE-1:0] inst;
  logic [WORD_SIZE-1:0] inst_pc;
  logic                 inst_ready;
  logic [WORD_SIZE-1:0] inst_count;
  logic [WORD_SIZE-1:0] stall_count;

  modport master (
    output mem_read, mem_addr, inst_valid, inst, inst_pc, inst_count, stall_count,
    input  mem_data, mem_ready, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_read, mem_addr, inst_valid, inst, inst_pc, inst_count, stall_count,
    output mem_data, mem_ready, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous prefetch FIFO (fetch_fifo). Pointers carry an extra MSB so that
// full and empty are distinguishable without a separate counter.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: request FSM, fetch PC, prefetch FIFO and counters.
// Optional decode-starvation counter enabled by defining IFU_STALL_COUNT_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input logic               clk,
  input logic               reset_n,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned ENTRY_W = ifu_entry_w(WORD_SIZE);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(FIFO_DEPTH - 1);

  ifu_state_e           r_state, w_state_nxt;
  logic [WORD_SIZE-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic                 r_mem_read, w_mem_read_nxt;
  logic [WORD_SIZE-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WORD_SIZE-1:0] r_inst_count;
  logic [WORD_SIZE-1:0] w_pc_inc;
  logic [WORD_SIZE-1:0] w_drop_pc;
  logic                 w_push, w_pop, w_flush;
  logic [ENTRY_W-1:0]   w_fifo_dout;
  logic [CW-1:0]        w_fifo_count;
  logic                 w_fifo_full, w_fifo_empty;

  assign w_pc_inc  = r_fetch_pc + WORD_SIZE'(1);
  assign w_drop_pc = bus.redirect ? bus.redirect_pc : r_fetch_pc;
  assign w_pop     = ~w_fifo_empty & bus.inst_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IFU_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_read <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_read <= w_mem_read_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_read_nxt = r_mem_read;
    w_mem_addr_nxt = r_mem_addr;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    unique case (r_state)
      IFU_IDLE: begin
        if (bus.redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = bus.redirect_pc;
        end else if (!w_fifo_full) begin
          w_state_nxt    = IFU_REQ;
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = r_fetch_pc;
        end
      end
      IFU_REQ: begin
        if (bus.redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = bus.redirect_pc;
          w_mem_read_nxt = 1'b0;
          w_state_nxt    = bus.mem_ready ? IFU_IDLE : IFU_DROP;
        end else if (bus.mem_ready) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
          // Room test counts the entry being pushed plus the next request.
          if (w_fifo_count < LAST_SLOT) begin
            w_mem_addr_nxt = w_pc_inc;
          end else begin
            w_mem_read_nxt = 1'b0;
            w_state_nxt    = IFU_IDLE;
          end
        end
      end
      IFU_DROP: begin
        w_fetch_pc_nxt = w_drop_pc;
        if (bus.mem_ready) begin
          if (!w_fifo_full) begin
            w_state_nxt    = IFU_REQ;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = w_drop_pc;
          end else begin
            w_state_nxt    = IFU_IDLE;
          end
        end
      end
      default: w_state_nxt = IFU_IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     ({r_fetch_pc, bus.mem_data}),
    .dout    (w_fifo_dout),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inst_count <= '0;
    else if (w_pop) r_inst_count <= r_inst_count + WORD_SIZE'(1);
  end

`ifdef IFU_STALL_COUNT_EN
  logic [WORD_SIZE-1:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stall_count <= '0;
    else if (bus.inst_ready && w_fifo_empty && !bus.redirect)
      r_stall_count <= r_stall_count + WORD_SIZE'(1);
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.mem_read   = r_mem_read;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.inst_count = r_inst_count;
  assign bus.inst_valid = ~w_fifo_empty;
  assign bus.inst       = w_fifo_empty ? '0 : w_fifo_dout[WORD_SIZE-1:0];
  assign bus.inst_pc    = w_fifo_empty ? '0 : w_fifo_dout[ENTRY_W-1:WORD_SIZE];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: table-driven streaming check plus
// hand-written back-pressure, redirect, wrap, stall-counter and reset sequences.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.WORD_SIZE(16)) bus ();

  inst_fetch_unit #(
    .WORD_SIZE  (16),
    .FIFO_DEPTH (4),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef IFU_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model: answers each request after a programmable number of cycles.
  int          base_lat  = 1;
  int          slow_lat  = 1;
  logic [15:0] slow_addr = 16'hDEAD;
  bit          pend;
  int          cnt;
  int          cur_lat;
  logic [15:0] req_addr;
  int          req_count;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.mem_ready = 1'b0;
      bus.mem_data  = '0;
      pend          = 1'b0;
      req_count     = 0;
    end else begin
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        pend          = 1'b0;
      end
      if (!pend && bus.mem_read) begin
        pend     = 1'b1;
        cnt      = 0;
        req_addr = bus.mem_addr;
        cur_lat  = (bus.mem_addr == slow_addr) ? slow_lat : base_lat;
        req_count++;
      end
      if (pend) begin
        cnt++;
        if (cnt >= cur_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_data  = mdata(req_addr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    @(posedge clk);
    #1;
    reset_n          = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.inst_ready   = 1'b0;
    #1;
    check("rst_mem_read", 16'(bus.mem_read), 16'h0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_inst_valid", 16'(bus.inst_valid), 16'h0);
    check("rst_inst", bus.inst, 16'h0);
    check("rst_inst_pc", bus.inst_pc, 16'h0);
    check("rst_inst_count", bus.inst_count, 16'h0);
    check("rst_stall_count", bus.stall_count, 16'h0);
    tick(2);
    base_lat       = lat;
    bus.inst_ready = rdy;
    reset_n        = 1'b1;
  endtask

  typedef struct {
    logic        inst_ready;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] st;
    bit          hit;

    st = STALL_EN ? 16'd2 : 16'd0;
    tbl[0] = '{1'b1, 16'd1, 16'd0, 16'd0, st};
    tbl[1] = '{1'b1, 16'd2, 16'd1, 16'd1, st};
    tbl[2] = '{1'b1, 16'd3, 16'd2, 16'd2, st};
    tbl[3] = '{1'b1, 16'd4, 16'd3, 16'd3, st};
    tbl[4] = '{1'b1, 16'd5, 16'd4, 16'd4, st};
    tbl[5] = '{1'b1, 16'd6, 16'd5, 16'd5, st};
    tbl[6] = '{1'b1, 16'd7, 16'd6, 16'd6, st};
    tbl[7] = '{1'b1, 16'd8, 16'd7, 16'd7, st};
    tbl[8] = '{1'b1, 16'd9, 16'd8, 16'd8, st};

    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;

    // Streaming, 1-cycle memory, decode always ready
    do_reset(1, 1'b1);
    tick(1);
    check("t1_first_addr", bus.mem_addr, 16'd0);
    for (int k = 0; k < 9; k++) begin
      bus.inst_ready = tbl[k].inst_ready;
      tick(1);
      check("t1_mem_read", 16'(bus.mem_read), 16'h1);
      check("t1_mem_addr", bus.mem_addr, tbl[k].exp_addr);
      check("t1_inst_valid", 16'(bus.inst_valid), 16'h1);
      check("t1_inst_pc", bus.inst_pc, tbl[k].exp_pc);
      check("t1_inst", bus.inst, mdata(tbl[k].exp_pc));
      check("t1_inst_count", bus.inst_count, tbl[k].exp_count);
      check("t1_stall_count", bus.stall_count, tbl[k].exp_stall);
    end

    // Back-pressure: FIFO fills after exactly four requests
    do_reset(1, 1'b0);
    tick(7);
    check("t2_mem_read_full", 16'(bus.mem_read), 16'h0);
    check("t2_req_count", 16'(req_count), 16'd4);
    check("t2_head_pc", bus.inst_pc, 16'd0);
    bus.inst_ready = 1'b1;
    tick(1);
    bus.inst_ready = 1'b0;
    check("t2_pop_count", bus.inst_count, 16'd1);
    check("t2_head_pc_after_pop", bus.inst_pc, 16'd1);
    check("t2_no_issue_yet", 16'(bus.mem_read), 16'h0);
    tick(1);
    check("t2_reissue_read", 16'(bus.mem_read), 16'h1);
    check("t2_reissue_addr", bus.mem_addr, 16'd4);

    // Redirect while the request to 5 is pending; its data arrives later
    slow_addr = 16'd5;
    slow_lat  = 4;
    do_reset(1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick(1);
      hit = bus.mem_read && (bus.mem_addr == 16'd5);
    end
    check("t3_wait_addr5", 16'(hit), 16'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick(1);
    bus.redirect = 1'b0;
    check("t3_drop_read", 16'(bus.mem_read), 16'h0);
    check("t3_flush_valid", 16'(bus.inst_valid), 16'h0);
    check("t3_count", bus.inst_count, 16'd5);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1);
      hit = bus.mem_read;
    end
    check("t3_wait_reissue", 16'(hit), 16'h1);
    check("t3_next_addr", bus.mem_addr, 16'h0040);
    hit = bus.inst_valid;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1);
      hit = bus.inst_valid;
    end
    check("t3_wait_valid", 16'(hit), 16'h1);
    check("t3_first_pc", bus.inst_pc, 16'h0040);
    check("t3_first_inst", bus.inst, mdata(16'h0040));
    slow_addr = 16'hDEAD;

    // Redirect and response in the same cycle, with a handshake accepted too
    do_reset(1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = bus.mem_ready && (bus.mem_addr == 16'd3);
    end
    check("t4_wait_ready3", 16'(hit), 16'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1234;
    bus.inst_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    check("t4_flush_valid", 16'(bus.inst_valid), 16'h0);
    check("t4_handshake_counted", bus.inst_count, 16'd1);
    check("t4_idle_read", 16'(bus.mem_read), 16'h0);
    tick(1);
    check("t4_req_read", 16'(bus.mem_read), 16'h1);
    check("t4_req_addr", bus.mem_addr, 16'h1234);
    tick(1);
    check("t4_valid", 16'(bus.inst_valid), 16'h1);
    check("t4_pc", bus.inst_pc, 16'h1234);
    check("t4_inst", bus.inst, mdata(16'h1234));

    // Address wrap at 16'hFFFF
    do_reset(1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1);
      hit = bus.mem_read;
    end
    check("t5_wait_first_req", 16'(hit), 16'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    tick(1);
    bus.redirect = 1'b0;
    hit = bus.inst_valid;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1);
      hit = bus.inst_valid;
    end
    check("t5_wait_valid", 16'(hit), 16'h1);
    check("t5_pc_ffff", bus.inst_pc, 16'hFFFF);
    check("t5_wrapped_addr", bus.mem_addr, 16'h0000);
    tick(1);
    check("t5_next_pc", bus.inst_pc, 16'h0000);
    check("t5_count", bus.inst_count, 16'd1);

    // Slow memory: decode starved two of every three cycles
    do_reset(3, 1'b1);
    tick(19);
    check("t6_inst_count", bus.inst_count, 16'd5);
    check("t6_stall_count", bus.stall_count, STALL_EN ? 16'd14 : 16'd0);

    // Reset in the middle of an outstanding request
    do_reset(10, 1'b0);
    tick(2);
    check("t7_pending_read", 16'(bus.mem_read), 16'h1);
    reset_n = 1'b0;
    #1;
    check("t7_abandon_read", 16'(bus.mem_read), 16'h0);
    check("t7_abandon_addr", bus.mem_addr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
